// File: rtl/fm_mod_envelope.sv
// fm_mod_envelope: per-voice ADSR envelope that scales a modulator sample into a carrier tuning-word offset
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid, in_chan         sample request and its voice index (indices >= NUM_CHAN are ignored)
//   note_on                   per-voice gate levels, sampled for the requested voice only
//   tuning_word, mod_signal   carrier tuning word and signed Q(WI).(WF) modulator sample
//   attack/decay/release_tau  Q4.28 envelope rates; sustain_lvl Q4.28 level; mod_depth Q4.4 depth
//   out_valid, out_chan       one-cycle result strobe and its voice, two edges after capture
//   modulated_tuning_word     tuning_word plus scaled modulation, wrapping mod 2^NUM_BITS
//   env_out                   updated envelope of the serviced voice (Q4.28)
//   env_active                per-voice flag, high while the voice is not idle
module fm_mod_envelope #(
   parameter int NUM_BITS = 32,
   parameter int WI = 2,
   parameter int WF = 16,
   parameter int NUM_CHAN = 16,
   localparam int CH_W = $clog2(NUM_CHAN)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [CH_W-1:0]             in_chan,
   input  logic [NUM_CHAN-1:0]         note_on,
   input  logic [NUM_BITS-1:0]         tuning_word,
   input  logic signed [WI+WF-1:0]     mod_signal,
   input  logic [31:0]                 attack_tau,
   input  logic [31:0]                 decay_tau,
   input  logic [31:0]                 release_tau,
   input  logic [31:0]                 sustain_lvl,
   input  logic [7:0]                  mod_depth,
   output logic                        out_valid,
   output logic [CH_W-1:0]             out_chan,
   output logic [NUM_BITS-1:0]         modulated_tuning_word,
   output logic [31:0]                 env_out,
   output logic [NUM_CHAN-1:0]         env_active
);
   typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
   localparam logic [31:0] PEAK    = 32'h1000_0000;
   localparam logic [31:0] ATK_TGT = 32'h1400_0000;
   localparam logic [31:0] EPS     = 32'h0010_0000;
   localparam logic [31:0] MIN     = 32'h0008_0000;
   state_t                     st_r [NUM_CHAN];
   logic [31:0]                env_r [NUM_CHAN];
   logic [NUM_CHAN-1:0]        np_r;
   logic                       v1, gate1, v2;
   logic [CH_W-1:0]            c1, c2;
   logic [NUM_BITS-1:0]        tw1, tw2;
   logic signed [WI+WF-1:0]    ms1, ms2;
   logic [31:0]                atk1, dec1, rel1, sus1, env2;
   logic [7:0]                 dep1, dep2;
   logic                       req;
   state_t                     st_in, st_a, st_n;
   logic [31:0]                e_in, tgt, tau, sat, env_n;
   logic signed [63:0]         sum;
   logic                       rise, fall, atk_done, dec_done, rel_done;
   logic signed [63:0]         m0, m1;
   logic [NUM_BITS-1:0]        m2;
   // the comparison is widened so a power-of-two NUM_CHAN does not make it constant
   assign req = in_valid && (32'(in_chan) < 32'(NUM_CHAN));
   // Stage 1 -> envelope update. A gate edge picks the state first; the rate and
   // target of that new state then drive this very update.
   always_comb begin
      st_in    = st_r[c1];
      e_in     = env_r[c1];
      rise     = gate1 && !np_r[c1];
      fall     = !gate1 && np_r[c1];
      st_a     = rise ? ATTACK
               : (fall && st_in != IDLE && st_in != RELEASE) ? RELEASE : st_in;
      tgt      = st_a == ATTACK ? ATK_TGT : st_a == DECAY ? sus1 : '0;
      tau      = st_a == ATTACK ? atk1 : st_a == DECAY ? dec1 : st_a == RELEASE ? rel1 : '0;
      sum      = $signed({32'b0, e_in})
               + (($signed({32'b0, tau}) * ($signed({32'b0, tgt}) - $signed({32'b0, e_in}))) >>> 28);
      sat      = sum < 0 ? '0 : sum > $signed({32'b0, PEAK}) ? PEAK : sum[31:0];
      atk_done = st_a == ATTACK && sat >= PEAK;
      // sat - sus <= EPS, evaluated without signed wrap
      dec_done = st_a == DECAY && ({1'b0, sat} <= {1'b0, sus1} + {1'b0, EPS});
      rel_done = st_a == RELEASE && sat < MIN;
      env_n    = (st_a == SUSTAIN || dec_done) ? sus1 : atk_done ? PEAK : rel_done ? '0 : sat;
      st_n     = atk_done ? DECAY : dec_done ? SUSTAIN : rel_done ? IDLE : st_a;
   end
   // The tuning word is taken as two's complement, so words above Nyquist act as
   // negative frequencies. 64-bit products hold every intermediate for the default widths.
   assign m0 = (64'($signed(tw2)) * 64'(ms2)) >>> WF;
   assign m1 = (m0 * $signed({32'b0, env2})) >>> 28;
   assign m2 = NUM_BITS'((m1 * $signed({56'b0, dep2})) >>> 4);
   for (genvar i = 0; i < NUM_CHAN; i++) begin : g_act
      assign env_active[i] = st_r[i] != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            st_r[i]  <= IDLE;
            env_r[i] <= '0;
         end
         np_r                  <= '0;
         v1                    <= 1'b0;
         gate1                 <= 1'b0;
         c1                    <= '0;
         tw1                   <= '0;
         ms1                   <= '0;
         atk1                  <= '0;
         dec1                  <= '0;
         rel1                  <= '0;
         sus1                  <= '0;
         dep1                  <= '0;
         v2                    <= 1'b0;
         c2                    <= '0;
         tw2                   <= '0;
         ms2                   <= '0;
         dep2                  <= '0;
         env2                  <= '0;
         out_valid             <= 1'b0;
         out_chan              <= '0;
         modulated_tuning_word <= '0;
         env_out               <= '0;
      end else begin
         v1 <= req;
         if (req) begin
            c1    <= in_chan;
            gate1 <= note_on[in_chan];
            tw1   <= tuning_word;
            ms1   <= mod_signal;
            atk1  <= attack_tau;
            dec1  <= decay_tau;
            rel1  <= release_tau;
            sus1  <= sustain_lvl;
            dep1  <= mod_depth;
         end
         v2 <= v1;
         if (v1) begin
            env_r[c1] <= env_n;
            st_r[c1]  <= st_n;
            np_r[c1]  <= gate1;
            c2        <= c1;
            tw2       <= tw1;
            ms2       <= ms1;
            dep2      <= dep1;
            env2      <= env_n;
         end
         out_valid <= v2;
         if (v2) begin
            out_chan              <= c2;
            modulated_tuning_word <= tw2 + m2;
            env_out               <= env2;
         end
      end
   end
endmodule

// File: tb/tb_fm_mod_envelope.sv
// tb_fm_mod_envelope: directed table-driven bench for fm_mod_envelope (12 voices so invalid indices exist)
module tb_fm_mod_envelope;
   localparam int NC = 12;
   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [3:0]    in_chan;
   logic [NC-1:0] note_on;
   logic [31:0]   tuning_word;
   logic [17:0]   mod_signal;
   logic [31:0]   attack_tau, decay_tau, release_tau, sustain_lvl;
   logic [7:0]    mod_depth;
   logic          out_valid;
   logic [3:0]    out_chan;
   logic [31:0]   modulated_tuning_word, env_out;
   logic [NC-1:0] env_active;
   fm_mod_envelope #(.NUM_CHAN(NC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan), .note_on(note_on),
      .tuning_word(tuning_word), .mod_signal(mod_signal), .attack_tau(attack_tau),
      .decay_tau(decay_tau), .release_tau(release_tau), .sustain_lvl(sustain_lvl),
      .mod_depth(mod_depth), .out_valid(out_valid), .out_chan(out_chan),
      .modulated_tuning_word(modulated_tuning_word), .env_out(env_out), .env_active(env_active)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic          vld;
      logic [3:0]    ch;
      logic [NC-1:0] non;
      logic [31:0]   tw;
      logic [17:0]   ms;
      logic [31:0]   atk, dec, rel, sus;
      logic [7:0]    dep;
      logic          ev;
      logic [31:0]   emtw, eenv;
   } vec_t;
   vec_t        tab[$];
   int          checks = 0;
   int          errors = 0;
   string       tag;
   logic [31:0] tw_c, atk_c, dec_c, rel_c, sus_c;
   logic [17:0] ms_c;
   logic [7:0]  dep_c;
   logic [31:0] dec_env [9] = '{32'h1000_0000, 32'h0C00_0000, 32'h0A00_0000, 32'h0900_0000,
                                32'h0880_0000, 32'h0840_0000, 32'h0820_0000, 32'h0800_0000,
                                32'h0800_0000};
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask
   task automatic add(input logic vld, input logic [3:0] ch, input logic [NC-1:0] non,
                      input logic ev, input logic [31:0] emtw, input logic [31:0] eenv);
      vec_t v;
      v.vld = vld; v.ch = ch; v.non = non; v.tw = tw_c; v.ms = ms_c;
      v.atk = atk_c; v.dec = dec_c; v.rel = rel_c; v.sus = sus_c; v.dep = dep_c;
      v.ev = ev; v.emtw = emtw; v.eenv = eenv;
      tab.push_back(v);
   endtask
   // vector i is driven before edge i; its result is registered at edge i+2
   task automatic run();
      int n = tab.size();
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) begin
            in_valid    = tab[i].vld;
            in_chan     = tab[i].ch;
            note_on     = tab[i].non;
            tuning_word = tab[i].tw;
            mod_signal  = tab[i].ms;
            attack_tau  = tab[i].atk;
            decay_tau   = tab[i].dec;
            release_tau = tab[i].rel;
            sustain_lvl = tab[i].sus;
            mod_depth   = tab[i].dep;
         end else in_valid = 1'b0;
         @(posedge clk); #1;
         if (i >= 2) begin
            chk($sformatf("%s[%0d].out_valid", tag, i - 2), 32'(out_valid), 32'(tab[i-2].ev));
            if (tab[i-2].ev) begin
               chk($sformatf("%s[%0d].out_chan", tag, i - 2), 32'(out_chan), 32'(tab[i-2].ch));
               chk($sformatf("%s[%0d].mtw", tag, i - 2), modulated_tuning_word, tab[i-2].emtw);
               chk($sformatf("%s[%0d].env_out", tag, i - 2), env_out, tab[i-2].eenv);
            end
         end
      end
      tab.delete();
   endtask
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_chan = '0; note_on = '0; tuning_word = '0; mod_signal = '0;
      attack_tau = '0; decay_tau = '0; release_tau = '0; sustain_lvl = '0; mod_depth = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.out_chan", 32'(out_chan), 32'd0);
      chk("reset.mtw", modulated_tuning_word, 32'd0);
      chk("reset.env_out", env_out, 32'd0);
      chk("reset.env_active", 32'(env_active), 32'd0);
      rst = 1'b0;
      // attack on ch3 to PEAK, decay->sustain at PEAK, then +/-0.5 modulation
      tag = "attack";
      tw_c = 32'h0100_0000; ms_c = 18'h08000; dep_c = 8'h10;
      atk_c = 32'h0800_0000; dec_c = '0; rel_c = 32'h0800_0000; sus_c = 32'h1000_0000;
      add(1, 3, 12'h008, 1, 32'h0150_0000, 32'h0A00_0000);
      add(1, 3, 12'h008, 1, 32'h0178_0000, 32'h0F00_0000);
      add(1, 3, 12'h008, 1, 32'h0180_0000, 32'h1000_0000);
      add(1, 3, 12'h008, 1, 32'h0180_0000, 32'h1000_0000);
      ms_c = 18'h38000;
      add(1, 3, 12'h008, 1, 32'h0080_0000, 32'h1000_0000);
      ms_c = 18'h08000;
      add(1, 12, 12'h008, 0, 32'h0, 32'h0);
      add(0, 3, 12'h008, 0, 32'h0, 32'h0);
      run();
      chk("attack.env_active", 32'(env_active), 32'h008);
      // release from PEAK halves per sample; 10th falls below MIN and goes idle
      tag = "release";
      for (int k = 1; k <= 10; k++)
         add(1, 3, 12'h000, 1, k == 10 ? 32'h0100_0000 : 32'h0100_0000 + (32'h0080_0000 >> k),
             k == 10 ? 32'h0 : 32'h1000_0000 >> k);
      run();
      chk("release.env_active", 32'(env_active), 32'h000);
      // interleaved voices with invalid indices in between
      tag = "interleave";
      atk_c = 32'h0800_0000; dep_c = 8'h10; add(1, 0, 12'h801, 1, 32'h0150_0000, 32'h0A00_0000);
      atk_c = 32'h0400_0000; dep_c = 8'h08; add(1, 11, 12'h801, 1, 32'h0114_0000, 32'h0500_0000);
      add(1, 12, 12'h801, 0, 32'h0, 32'h0);
      atk_c = 32'h0800_0000; dep_c = 8'h10; add(1, 0, 12'h801, 1, 32'h0178_0000, 32'h0F00_0000);
      add(1, 15, 12'h801, 0, 32'h0, 32'h0);
      atk_c = 32'h0400_0000; dep_c = 8'h08; add(1, 11, 12'h801, 1, 32'h0123_0000, 32'h08C0_0000);
      run();
      chk("interleave.env_active", 32'(env_active), 32'h801);
      // asynchronous reset with one result on the output and one still in flight
      atk_c = 32'h0800_0000; dep_c = 8'h10;
      in_valid = 1'b1; in_chan = 4'd0; note_on = 12'h801; attack_tau = atk_c; mod_depth = dep_c;
      @(posedge clk); #1;
      in_chan = 4'd11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midrst.pre_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst.out_valid", 32'(out_valid), 32'd0);
      chk("midrst.mtw", modulated_tuning_word, 32'd0);
      chk("midrst.env_out", env_out, 32'd0);
      chk("midrst.env_active", 32'(env_active), 32'd0);
      @(posedge clk); #1;
      chk("midrst.dropped", 32'(out_valid), 32'd0);
      rst = 1'b0;
      tag = "after_rst";
      add(1, 3, 12'h009, 1, 32'h0150_0000, 32'h0A00_0000);
      add(1, 0, 12'h009, 1, 32'h0150_0000, 32'h0A00_0000);
      run();
      // wrap past 2^32: tuning word 0xFFFF0000 with m2 = 0x20000, then 0x40000
      tag = "wrap";
      tw_c = 32'hFFFF_0000; ms_c = 18'h20000; atk_c = 32'h0E00_0000; dec_c = '0;
      sus_c = 32'h1000_0000; dep_c = 8'h10;
      add(1, 5, 12'h029, 1, 32'h0001_0000, 32'h1000_0000);
      dep_c = 8'h20;
      add(1, 5, 12'h029, 1, 32'h0003_0000, 32'h1000_0000);
      run();
      // decay toward sustain, snapping once within EPS, then holding
      tag = "decay";
      tw_c = 32'h0100_0000; ms_c = 18'h08000; dep_c = 8'h10;
      atk_c = 32'h0E00_0000; dec_c = 32'h0800_0000; sus_c = 32'h0800_0000;
      for (int k = 0; k < 9; k++)
         add(1, 7, 12'h0A9, 1, 32'h0100_0000 + (dec_env[k] >> 5), dec_env[k]);
      run();
      chk("final.env_active", 32'(env_active), 32'h0A9);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
